// File: rtl/axi_arb_pkg.sv
// ---------------------------------------------------------------------------
// axi_arb_pkg : shared types and constants for the two-port AXI read arbiter
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package axi_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_t;

  localparam logic [2:0] C_DEF_ARSIZE  = 3'b010;
  localparam logic [1:0] C_DEF_ARBURST = 2'b01;
  localparam int         REQ_IDX_W     = 1;

endpackage : axi_arb_pkg

`default_nettype wire

// File: rtl/axi_rd_outstanding_ctr.sv
// ---------------------------------------------------------------------------
// axi_rd_outstanding_ctr : per-requester count of accepted, uncompleted bursts
// Revision               : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axi_rd_outstanding_ctr #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_inc,
  input  logic       i_dec,
  output logic [2:0] o_count,
  output logic       o_full,
  output logic       o_err
);

  localparam logic [2:0] C_MAX = 3'(MAX_OUTSTANDING);

  logic [2:0] r_count;
  logic       r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 3'd0;
      r_err   <= 1'b0;
    end else begin
      case ({i_inc, i_dec})
        2'b10: begin
          if (!o_full) r_count <= r_count + 3'd1;
        end
        2'b01: begin
          // A completion with nothing outstanding is a protocol error; count saturates at 0.
          if (r_count == 3'd0) r_err <= 1'b1;
          else                 r_count <= r_count - 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_full  = (r_count >= C_MAX);
  assign o_err   = r_err;

endmodule : axi_rd_outstanding_ctr

`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter : two-requester round-robin AXI read arbiter with ID-based
//                  R routing and per-requester outstanding limits
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ID_W            = 4
) (
  input  logic            ACLK,
  input  logic            ARESET,

  input  logic [31:0]     S0_ARADDR,
  input  logic [ID_W-1:0] S0_ARID,
  input  logic [7:0]      S0_ARLEN,
  input  logic [2:0]      S0_ARSIZE,
  input  logic [1:0]      S0_ARBURST,
  input  logic            S0_ARVALID,
  output logic            S0_ARREADY,
  output logic [31:0]     S0_RDATA,
  output logic [1:0]      S0_RRESP,
  output logic [ID_W-1:0] S0_RID,
  output logic            S0_RLAST,
  output logic            S0_RVALID,
  input  logic            S0_RREADY,

  input  logic [31:0]     S1_ARADDR,
  input  logic [ID_W-1:0] S1_ARID,
  input  logic [7:0]      S1_ARLEN,
  input  logic [2:0]      S1_ARSIZE,
  input  logic [1:0]      S1_ARBURST,
  input  logic            S1_ARVALID,
  output logic            S1_ARREADY,
  output logic [31:0]     S1_RDATA,
  output logic [1:0]      S1_RRESP,
  output logic [ID_W-1:0] S1_RID,
  output logic            S1_RLAST,
  output logic            S1_RVALID,
  input  logic            S1_RREADY,

  output logic [31:0]     M_AXI_ARADDR,
  output logic [ID_W:0]   M_AXI_ARID,
  output logic [7:0]      M_AXI_ARLEN,
  output logic [2:0]      M_AXI_ARSIZE,
  output logic [1:0]      M_AXI_ARBURST,
  output logic            M_AXI_ARVALID,
  input  logic            M_AXI_ARREADY,

  input  logic [31:0]     M_AXI_RDATA,
  input  logic [1:0]      M_AXI_RRESP,
  input  logic [ID_W:0]   M_AXI_RID,
  input  logic            M_AXI_RLAST,
  input  logic            M_AXI_RVALID,
  output logic            M_AXI_RREADY,

  output logic [2:0]      OUTSTANDING0,
  output logic [2:0]      OUTSTANDING1,
  output logic            RD_ERR
);

  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  logic [REQ_IDX_W-1:0] r_last_grant;

  logic [31:0]   r_araddr;
  logic [ID_W:0] r_arid;
  logic [7:0]    r_arlen;
  logic [2:0]    r_arsize;
  logic [1:0]    r_arburst;

  logic w_full0, w_full1, w_err0, w_err1;
  logic w_elig0, w_elig1, w_gnt0, w_gnt1, w_arb_open;
  logic w_hs0, w_hs1;
  logic w_rsel, w_rlast_hs, w_dec0, w_dec1;

  // Grant decision only looks at registered state and S-side inputs, never at M_AXI_ARREADY.
  assign w_elig0    = S0_ARVALID && !w_full0;
  assign w_elig1    = S1_ARVALID && !w_full1;
  assign w_gnt1     = w_elig1 && (!w_elig0 || (r_last_grant == 1'b0));
  assign w_gnt0     = w_elig0 && !w_gnt1;
  assign w_arb_open = (r_state == ST_IDLE) && !ARESET;

  assign S0_ARREADY = w_arb_open && w_gnt0;
  assign S1_ARREADY = w_arb_open && w_gnt1;
  assign w_hs0      = S0_ARVALID && S0_ARREADY;
  assign w_hs1      = S1_ARVALID && S1_ARREADY;

  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_hs0 || w_hs1)                  w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (M_AXI_ARVALID && M_AXI_ARREADY)  w_state_nxt = ST_IDLE;
      default:                                       w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_last_grant <= 1'b1;
      r_araddr     <= 32'd0;
      r_arid       <= '0;
      r_arlen      <= 8'd0;
      r_arsize     <= C_DEF_ARSIZE;
      r_arburst    <= C_DEF_ARBURST;
    end else if (w_hs0) begin
      r_last_grant <= 1'b0;
      r_araddr     <= S0_ARADDR;
      r_arid       <= {1'b0, S0_ARID};
      r_arlen      <= S0_ARLEN;
      r_arsize     <= S0_ARSIZE;
      r_arburst    <= S0_ARBURST;
    end else if (w_hs1) begin
      r_last_grant <= 1'b1;
      r_araddr     <= S1_ARADDR;
      r_arid       <= {1'b1, S1_ARID};
      r_arlen      <= S1_ARLEN;
      r_arsize     <= S1_ARSIZE;
      r_arburst    <= S1_ARBURST;
    end
  end

  assign M_AXI_ARVALID = (r_state == ST_ISSUE);
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARID    = r_arid;
  assign M_AXI_ARLEN   = r_arlen;
  assign M_AXI_ARSIZE  = r_arsize;
  assign M_AXI_ARBURST = r_arburst;

  // The upper RID bit names the requester that issued the burst.
  assign w_rsel       = M_AXI_RID[ID_W];
  assign M_AXI_RREADY = w_rsel ? S1_RREADY : S0_RREADY;
  assign S0_RVALID    = M_AXI_RVALID && !w_rsel;
  assign S1_RVALID    = M_AXI_RVALID &&  w_rsel;
  assign S0_RDATA     = M_AXI_RDATA;
  assign S1_RDATA     = M_AXI_RDATA;
  assign S0_RRESP     = M_AXI_RRESP;
  assign S1_RRESP     = M_AXI_RRESP;
  assign S0_RLAST     = M_AXI_RLAST;
  assign S1_RLAST     = M_AXI_RLAST;
  assign S0_RID       = M_AXI_RID[ID_W-1:0];
  assign S1_RID       = M_AXI_RID[ID_W-1:0];

  assign w_rlast_hs = M_AXI_RVALID && M_AXI_RREADY && M_AXI_RLAST;
  assign w_dec0     = w_rlast_hs && !w_rsel;
  assign w_dec1     = w_rlast_hs &&  w_rsel;

  axi_rd_outstanding_ctr #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_ctr0 (
    .clk     (ACLK),
    .rst     (ARESET),
    .i_inc   (w_hs0),
    .i_dec   (w_dec0),
    .o_count (OUTSTANDING0),
    .o_full  (w_full0),
    .o_err   (w_err0)
  );

  axi_rd_outstanding_ctr #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_ctr1 (
    .clk     (ACLK),
    .rst     (ARESET),
    .i_inc   (w_hs1),
    .i_dec   (w_dec1),
    .o_count (OUTSTANDING1),
    .o_full  (w_full1),
    .o_err   (w_err1)
  );

  assign RD_ERR = w_err0 || w_err1;

endmodule : axi_rd_arbiter

`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_arbiter : directed self-checking bench for axi_rd_arbiter
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_axi_rd_arbiter;

  localparam int ID_W = 4;

  logic            ACLK = 1'b0;
  logic            ARESET;
  logic [31:0]     S0_ARADDR, S1_ARADDR;
  logic [ID_W-1:0] S0_ARID, S1_ARID;
  logic [7:0]      S0_ARLEN, S1_ARLEN;
  logic [2:0]      S0_ARSIZE, S1_ARSIZE;
  logic [1:0]      S0_ARBURST, S1_ARBURST;
  logic            S0_ARVALID, S1_ARVALID;
  logic            S0_ARREADY, S1_ARREADY;
  logic [31:0]     S0_RDATA, S1_RDATA;
  logic [1:0]      S0_RRESP, S1_RRESP;
  logic [ID_W-1:0] S0_RID, S1_RID;
  logic            S0_RLAST, S1_RLAST, S0_RVALID, S1_RVALID;
  logic            S0_RREADY, S1_RREADY;
  logic [31:0]     M_AXI_ARADDR;
  logic [ID_W:0]   M_AXI_ARID;
  logic [7:0]      M_AXI_ARLEN;
  logic [2:0]      M_AXI_ARSIZE;
  logic [1:0]      M_AXI_ARBURST;
  logic            M_AXI_ARVALID, M_AXI_ARREADY;
  logic [31:0]     M_AXI_RDATA;
  logic [1:0]      M_AXI_RRESP;
  logic [ID_W:0]   M_AXI_RID;
  logic            M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;
  logic [2:0]      OUTSTANDING0, OUTSTANDING1;
  logic            RD_ERR;

  int n_checks = 0;
  int n_errors = 0;

  always #5 ACLK = ~ACLK;

  axi_rd_arbiter #(.MAX_OUTSTANDING(4), .ID_W(ID_W)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S0_ARADDR(S0_ARADDR), .S0_ARID(S0_ARID), .S0_ARLEN(S0_ARLEN), .S0_ARSIZE(S0_ARSIZE),
    .S0_ARBURST(S0_ARBURST), .S0_ARVALID(S0_ARVALID), .S0_ARREADY(S0_ARREADY),
    .S0_RDATA(S0_RDATA), .S0_RRESP(S0_RRESP), .S0_RID(S0_RID), .S0_RLAST(S0_RLAST),
    .S0_RVALID(S0_RVALID), .S0_RREADY(S0_RREADY),
    .S1_ARADDR(S1_ARADDR), .S1_ARID(S1_ARID), .S1_ARLEN(S1_ARLEN), .S1_ARSIZE(S1_ARSIZE),
    .S1_ARBURST(S1_ARBURST), .S1_ARVALID(S1_ARVALID), .S1_ARREADY(S1_ARREADY),
    .S1_RDATA(S1_RDATA), .S1_RRESP(S1_RRESP), .S1_RID(S1_RID), .S1_RLAST(S1_RLAST),
    .S1_RVALID(S1_RVALID), .S1_RREADY(S1_RREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RID(M_AXI_RID),
    .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .OUTSTANDING0(OUTSTANDING0), .OUTSTANDING1(OUTSTANDING1), .RD_ERR(RD_ERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Present one AR on requester n and wait (bounded) for its handshake.
  task automatic do_ar(input int n, input logic [31:0] addr, input logic [ID_W-1:0] id,
                       input logic [7:0] len);
    bit done = 0;
    if (n == 0) begin
      S0_ARADDR = addr; S0_ARID = id; S0_ARLEN = len; S0_ARVALID = 1'b1;
    end else begin
      S1_ARADDR = addr; S1_ARID = id; S1_ARLEN = len; S1_ARVALID = 1'b1;
    end
    for (int i = 0; i < 8 && !done; i++) begin
      #1;
      if ((n == 0) ? S0_ARREADY : S1_ARREADY) done = 1;
      tick();
    end
    S0_ARVALID = 1'b0;
    S1_ARVALID = 1'b0;
    if (!done) chk("ar_timeout", 32'(done), 32'd1);
  endtask

  task automatic r_beat(input logic [ID_W:0] rid, input logic last, input logic [31:0] data);
    M_AXI_RVALID = 1'b1; M_AXI_RID = rid; M_AXI_RLAST = last; M_AXI_RDATA = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1;
    S0_ARADDR = '0; S0_ARID = '0; S0_ARLEN = '0; S0_ARSIZE = 3'b010; S0_ARBURST = 2'b01;
    S1_ARADDR = '0; S1_ARID = '0; S1_ARLEN = '0; S1_ARSIZE = 3'b010; S1_ARBURST = 2'b01;
    S0_ARVALID = 1'b1; S1_ARVALID = 1'b0;
    S0_RREADY = 1'b0; S1_RREADY = 1'b0;
    M_AXI_ARREADY = 1'b0;
    M_AXI_RDATA = '0; M_AXI_RRESP = '0; M_AXI_RID = '0; M_AXI_RLAST = 1'b0; M_AXI_RVALID = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_arvalid",  32'(M_AXI_ARVALID), 32'd0);
    chk("rst_araddr",   M_AXI_ARADDR,       32'd0);
    chk("rst_arid",     32'(M_AXI_ARID),    32'd0);
    chk("rst_arlen",    32'(M_AXI_ARLEN),   32'd0);
    chk("rst_arsize",   32'(M_AXI_ARSIZE),  32'd2);
    chk("rst_arburst",  32'(M_AXI_ARBURST), 32'd1);
    chk("rst_out0",     32'(OUTSTANDING0),  32'd0);
    chk("rst_out1",     32'(OUTSTANDING1),  32'd0);
    chk("rst_rderr",    32'(RD_ERR),        32'd0);
    chk("rst_s0_ready", 32'(S0_ARREADY),    32'd0);

    // Simultaneous requests: S0 wins first tie
    ARESET = 1'b0;
    S0_ARADDR = 32'h40; S0_ARID = 4'h3; S0_ARLEN = 8'd3; S0_ARVALID = 1'b1;
    S1_ARADDR = 32'h80; S1_ARID = 4'h5; S1_ARLEN = 8'd1; S1_ARVALID = 1'b1;
    #1;
    chk("tie_s0_ready", 32'(S0_ARREADY), 32'd1);
    chk("tie_s1_ready", 32'(S1_ARREADY), 32'd0);
    tick();
    S0_ARVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_arvalid", 32'(M_AXI_ARVALID), 32'd1);
      chk("hold_arid",    32'(M_AXI_ARID),    32'h03);
      chk("hold_araddr",  M_AXI_ARADDR,       32'h40);
      chk("hold_arlen",   32'(M_AXI_ARLEN),   32'd3);
      chk("hold_s1_rdy",  32'(S1_ARREADY),    32'd0);
      if (i < 2) tick();
    end
    chk("out0_after_ar", 32'(OUTSTANDING0), 32'd1);
    M_AXI_ARREADY = 1'b1;
    tick();
    chk("ar_drop",      32'(M_AXI_ARVALID), 32'd0);
    chk("s1_ready_rr",  32'(S1_ARREADY),    32'd1);
    tick();
    S1_ARVALID = 1'b0;
    chk("s1_arid",      32'(M_AXI_ARID),    32'h15);
    chk("s1_araddr",    M_AXI_ARADDR,       32'h80);
    chk("s1_arvalid",   32'(M_AXI_ARVALID), 32'd1);
    chk("out1_after_ar", 32'(OUTSTANDING1), 32'd1);
    tick();
    chk("s1_ar_drop",   32'(M_AXI_ARVALID), 32'd0);

    // 4-beat burst routed to S1
    S1_RREADY = 1'b1; S0_RREADY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r_beat(5'h13, (i == 3), 32'hA0 + 32'(i));
      #1;
      chk("r1_s1_valid", 32'(S1_RVALID),    32'd1);
      chk("r1_s0_valid", 32'(S0_RVALID),    32'd0);
      chk("r1_rid",      32'(S1_RID),       32'd3);
      chk("r1_data",     S1_RDATA,          32'hA0 + 32'(i));
      chk("r1_rready",   32'(M_AXI_RREADY), 32'd1);
      chk("r1_out1",     32'(OUTSTANDING1), 32'd1);
      tick();
    end
    M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
    chk("r1_out1_done", 32'(OUTSTANDING1), 32'd0);

    // Fill S0 to the limit, then S1 still wins
    do_ar(0, 32'h100, 4'h1, 8'd0);
    do_ar(0, 32'h200, 4'h2, 8'd0);
    do_ar(0, 32'h300, 4'h4, 8'd0);
    tick();
    chk("out0_full", 32'(OUTSTANDING0), 32'd4);
    S0_ARVALID = 1'b1; S1_ARVALID = 1'b1; S1_ARID = 4'h2; S1_ARADDR = 32'h500;
    #1;
    chk("full_s0_rdy", 32'(S0_ARREADY), 32'd0);
    chk("full_s1_rdy", 32'(S1_ARREADY), 32'd1);
    tick();
    S1_ARVALID = 1'b0;
    chk("full_s1_arid", 32'(M_AXI_ARID),   32'h12);
    chk("full_out1",    32'(OUTSTANDING1), 32'd1);
    tick();
    chk("stall_s0_rdy", 32'(S0_ARREADY),   32'd0);
    chk("stall_out0",   32'(OUTSTANDING0), 32'd4);
    S0_ARVALID = 1'b0;

    // One S0 completion, then simultaneous AR + RLAST on S0
    S0_RREADY = 1'b1;
    r_beat(5'h01, 1'b1, 32'h55);
    #1;
    chk("r0_s0_valid", 32'(S0_RVALID), 32'd1);
    chk("r0_s1_valid", 32'(S1_RVALID), 32'd0);
    chk("r0_rid",      32'(S0_RID),    32'd1);
    tick();
    M_AXI_RVALID = 1'b0;
    chk("r0_out0", 32'(OUTSTANDING0), 32'd3);
    S0_ARADDR = 32'h700; S0_ARID = 4'h7; S0_ARVALID = 1'b1;
    r_beat(5'h07, 1'b1, 32'h66);
    #1;
    chk("both_s0_rdy", 32'(S0_ARREADY), 32'd1);
    tick();
    S0_ARVALID = 1'b0; M_AXI_RVALID = 1'b0;
    chk("both_out0", 32'(OUTSTANDING0), 32'd3);
    chk("both_arid", 32'(M_AXI_ARID),   32'h07);
    tick();

    // Reset while an AR is pending downstream
    M_AXI_ARREADY = 1'b0;
    do_ar(1, 32'h900, 4'h9, 8'd2);
    chk("pend_arvalid", 32'(M_AXI_ARVALID), 32'd1);
    ARESET = 1'b1; S1_ARVALID = 1'b1;
    #1;
    chk("rst_s1_ready", 32'(S1_ARREADY), 32'd0);
    tick();
    chk("mid_rst_arvalid", 32'(M_AXI_ARVALID), 32'd0);
    chk("mid_rst_arid",    32'(M_AXI_ARID),    32'd0);
    chk("mid_rst_out0",    32'(OUTSTANDING0),  32'd0);
    chk("mid_rst_out1",    32'(OUTSTANDING1),  32'd0);
    ARESET = 1'b0; S1_ARVALID = 1'b0;
    tick();
    chk("post_rst_arvalid", 32'(M_AXI_ARVALID), 32'd0);

    // RLAST to S0 with nothing outstanding sets the sticky error
    r_beat(5'h00, 1'b1, 32'h77);
    tick();
    M_AXI_RVALID = 1'b0;
    chk("err_set",  32'(RD_ERR),       32'd1);
    chk("err_out0", 32'(OUTSTANDING0), 32'd0);
    tick(); tick(); tick();
    chk("err_sticky", 32'(RD_ERR), 32'd1);
    ARESET = 1'b1;
    tick();
    chk("err_clear", 32'(RD_ERR), 32'd0);
    ARESET = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_axi_rd_arbiter

`default_nettype wire
